// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, two-flop input synchronizer and a
// valid/ack output handshake; baud rate chosen per frame by baud_sel.
module uart_rx #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [2:0] baud_sel,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    function automatic int div_for(input int baud);
        return (CLK_HZ + 8 * baud) / (16 * baud);
    endfunction

    localparam logic [15:0] MAX_4800   = 16'(div_for(4800) - 1);
    localparam logic [15:0] MAX_9600   = 16'(div_for(9600) - 1);
    localparam logic [15:0] MAX_19200  = 16'(div_for(19200) - 1);
    localparam logic [15:0] MAX_38400  = 16'(div_for(38400) - 1);
    localparam logic [15:0] MAX_57600  = 16'(div_for(57600) - 1);
    localparam logic [15:0] MAX_115200 = 16'(div_for(115200) - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        fall;
    logic [2:0]  baud_lat;
    logic [15:0] div_cnt;
    logic [15:0] div_max;
    logic        tick;
    logic [3:0]  sample_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        start_frame;
    logic        clr_sample;
    logic        shift_en;
    logic        stop_eval;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev & ~rx_sync;

    always_comb begin
        case (baud_lat)
            3'b000:  div_max = MAX_4800;
            3'b001:  div_max = MAX_19200;
            3'b010:  div_max = MAX_38400;
            3'b011:  div_max = MAX_57600;
            3'b101:  div_max = MAX_115200;
            default: div_max = MAX_9600;
        endcase
    end

    assign tick = (state != IDLE) && (div_cnt == div_max);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Start bit is checked at its middle (8th tick); later bits every 16 ticks.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        clr_sample  = 1'b0;
        shift_en    = 1'b0;
        stop_eval   = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_next  = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (tick && sample_cnt == 4'd7) begin
                    if (!rx_sync) begin
                        state_next = DATA;
                        clr_sample = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick && sample_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && sample_cnt == 4'd15) begin
                    stop_eval  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_lat   <= 3'b100;
            div_cnt    <= '0;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
        end else begin
            if (start_frame) begin
                baud_lat <= baud_sel;
            end
            if (state == IDLE || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
            if (start_frame || clr_sample) begin
                sample_cnt <= '0;
            end else if (tick) begin
                sample_cnt <= sample_cnt + 4'd1;
            end
            if (start_frame) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) begin
                shift_reg <= {rx_sync, shift_reg[7:1]};
            end
        end
    end

    // A byte load takes priority over a simultaneous ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data        <= 8'h00;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= stop_eval & ~rx_sync;
            overrun     <= stop_eval & rx_sync & valid;
            if (stop_eval && rx_sync) begin
                data  <= shift_reg;
                valid <= 1'b1;
            end else if (ack) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven at 16*DIV cycles per bit, with
// the receiver run at 12.5 MHz so that even 9600 baud frames stay short.
module tb_uart_rx;

    localparam int CLK_HZ = 12_500_000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [2:0] baud_sel = 3'b100;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;
    int valid_rises = 0;
    int fe_cycles = 0;
    int ovr_cycles = 0;
    logic valid_prev = 1'b0;

    uart_rx #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .baud_sel(baud_sel),
        .ack(ack),
        .data(data),
        .valid(valid),
        .framing_err(framing_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #40 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && !valid_prev) valid_rises++;
            if (framing_err) fe_cycles++;
            if (overrun) ovr_cycles++;
        end
        valid_prev = valid;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    // Hand-computed round(12.5e6 / (16 * baud)).
    function automatic int div_of(input logic [2:0] sel);
        case (sel)
            3'b000:  return 163;
            3'b001:  return 41;
            3'b010:  return 20;
            3'b011:  return 14;
            3'b101:  return 7;
            default: return 81;
        endcase
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic [2:0] sel,
                              input logic stop_bit, input logic scramble);
        int bc;
        bc = 16 * div_of(sel);
        baud_sel = sel;
        drive_bit(1'b0, bc);
        if (scramble) baud_sel = ~sel;
        for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
        drive_bit(stop_bit, bc);
        baud_sel = sel;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({data, valid, framing_err, overrun, busy} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected 000",
                     {data, valid, framing_err, overrun, busy});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_loopback_9600;
        int vr0, fe0, ov0;
        vr0 = valid_rises; fe0 = fe_cycles; ov0 = ovr_cycles;
        send_frame(8'h55, 3'b100, 1'b1, 1'b1);
        tests_run++;
        if (valid_rises - vr0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL lb9600_valid_rises: got %0d expected 1", valid_rises - vr0);
        end
        tests_run++;
        if (data !== 8'h55) begin
            tests_failed++;
            $display("[TB] FAIL lb9600_data: got %h expected 55", data);
        end
        tests_run++;
        if ((fe_cycles - fe0) + (ovr_cycles - ov0) !== 0) begin
            tests_failed++;
            $display("[TB] FAIL lb9600_errors: got fe=%0d ovr=%0d expected 0 0",
                     fe_cycles - fe0, ovr_cycles - ov0);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lb9600_busy: got %b expected 0", busy);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_ack;
        logic [7:0] bytes [2] = '{8'hAA, 8'hEF};
        logic [2:0] sels  [2] = '{3'b010, 3'b011};
        for (int k = 0; k < 2; k++) begin
            send_frame(bytes[k], sels[k], 1'b1, 1'b0);
            tests_run++;
            if (data !== bytes[k] || valid !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL ack_data_%0d: got data=%h valid=%b expected %h 1",
                         k, data, valid, bytes[k]);
            end
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            tests_run++;
            if (valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL ack_clear_%0d: got valid=%b expected 0", k, valid);
            end
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0 || data !== 8'hEF) begin
            tests_failed++;
            $display("[TB] FAIL ack_idle: got valid=%b data=%h expected 0 ef", valid, data);
        end
    endtask

    task automatic test_glitch;
        int vr0, fe0;
        vr0 = valid_rises; fe0 = fe_cycles;
        baud_sel = 3'b100;
        rx = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (busy !== (i == 3)) begin
                tests_failed++;
                $display("[TB] FAIL glitch_latency_%0d: got busy=%b expected %b", i, busy, i == 3);
            end
        end
        repeat (35) @(negedge clk);
        rx = 1'b1;
        repeat (8 * 81 + 40) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_abort: got busy=%b expected 0", busy);
        end
        tests_run++;
        if (valid_rises - vr0 !== 0 || fe_cycles - fe0 !== 0 || valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_no_output: got rises=%0d fe=%0d valid=%b expected 0 0 0",
                     valid_rises - vr0, fe_cycles - fe0, valid);
        end
    endtask

    task automatic test_framing;
        int vr0, fe0;
        vr0 = valid_rises; fe0 = fe_cycles;
        send_frame(8'h3C, 3'b101, 1'b0, 1'b0);
        tests_run++;
        if (fe_cycles - fe0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL framing_pulse: got %0d cycles expected 1", fe_cycles - fe0);
        end
        tests_run++;
        if (data !== 8'hEF || valid !== 1'b0 || valid_rises != vr0) begin
            tests_failed++;
            $display("[TB] FAIL framing_hold: got data=%h valid=%b expected ef 0", data, valid);
        end
        // Line stays low (break): no new falling edge, so no new frame.
        repeat (3 * 112) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL break_no_retrigger: got busy=%b expected 0", busy);
        end
        drive_bit(1'b1, 2 * 112);
    endtask

    task automatic test_back_to_back;
        int ov0;
        ov0 = ovr_cycles;
        send_frame(8'h12, 3'b011, 1'b1, 1'b0);
        tests_run++;
        if (data !== 8'h12 || valid !== 1'b1 || ovr_cycles != ov0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got data=%h valid=%b ovr=%0d expected 12 1 0",
                     data, valid, ovr_cycles - ov0);
        end
        send_frame(8'h34, 3'b011, 1'b1, 1'b0);
        tests_run++;
        if (data !== 8'h34 || valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: got data=%h valid=%b expected 34 1", data, valid);
        end
        tests_run++;
        if (ovr_cycles - ov0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_overrun: got %0d cycles expected 1", ovr_cycles - ov0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int ov0;
        baud_sel = 3'b101;
        drive_bit(1'b0, 112);
        drive_bit(1'b1, 112);
        drive_bit(1'b0, 112);
        drive_bit(1'b1, 112);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midframe_busy: got busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({data, valid, framing_err, overrun, busy} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL midframe_reset: got %h expected 000",
                     {data, valid, framing_err, overrun, busy});
        end
        rst_n = 1'b1;
        drive_bit(1'b1, 2 * 112);
        ov0 = ovr_cycles;
        send_frame(8'hA5, 3'b101, 1'b1, 1'b0);
        tests_run++;
        if (data !== 8'hA5 || valid !== 1'b1 || ovr_cycles != ov0) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_rx: got data=%h valid=%b ovr=%0d expected a5 1 0",
                     data, valid, ovr_cycles - ov0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_loopback_9600;
        test_ack;
        test_glitch;
        test_framing;
        test_back_to_back;
        test_reset_mid_frame;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
